// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_50MHZ = 1_000_000;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module btn_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic out_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
    end
  end

  assign out_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Button debouncer: polarity fix, 2-FF synchroniser, hold-counter FSM,
// registered level, press/release strobes and a press-toggled flag.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_50MHZ,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic pol;
  logic s;

  assign pol = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

  btn_sync2 u_sync (
    .clk   (clk),
    .rst   (rst),
    .in_i  (pol),
    .out_o (s)
  );

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;

  // A bounce back to the stable value abandons the check with no partial credit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CHECK_HI;
          cnt_d   = '0;
        end
      end
      CHECK_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          level_d  = 1'b1;
          press_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CHECK_LO;
          cnt_d   = '0;
        end
      end
      CHECK_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE_LO;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: active-high and active-low instances driven by the same
// logical button, checked every cycle against a run-length model plus directed timing checks.
module tb_button_debounce;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic btn_n;

  logic lvl_a, prs_a, rel_a, tgl_a;
  logic lvl_b, prs_b, rel_b, tgl_b;

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  button_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .btn_i(btn),
    .level_o(lvl_a), .press_o(prs_a), .release_o(rel_a), .toggle_o(tgl_a)
  );

  button_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .btn_i(btn_n),
    .level_o(lvl_b), .press_o(prs_b), .release_o(rel_b), .toggle_o(tgl_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pin history, run length of synchronised samples differing from level
  logic hist1, hist2;
  int   run;
  logic m_lvl, m_prs, m_rel, m_tgl;

  int cyc = 0;
  int press_cnt = 0;
  int release_cnt = 0;
  int last_press = -1;
  int last_release = -1;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic r, input logic p);
    logic s;
    if (r) begin
      hist1 = 1'b0; hist2 = 1'b0; run = 0;
      m_lvl = 1'b0; m_prs = 1'b0; m_rel = 1'b0; m_tgl = 1'b0;
    end else begin
      s = hist2;
      hist2 = hist1;
      hist1 = p;
      m_prs = 1'b0;
      m_rel = 1'b0;
      if (s != m_lvl) begin
        run++;
        if (run == D + 1) begin
          m_lvl = s;
          m_prs = s;
          m_rel = ~s;
          if (s) m_tgl = ~m_tgl;
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst, btn);
    cyc++;
    #1;
    chk("level", int'(lvl_a), int'(m_lvl));
    chk("press", int'(prs_a), int'(m_prs));
    chk("release", int'(rel_a), int'(m_rel));
    chk("toggle", int'(tgl_a), int'(m_tgl));
    chk("al_level", int'(lvl_b), int'(m_lvl));
    chk("al_press", int'(prs_b), int'(m_prs));
    chk("al_release", int'(rel_b), int'(m_rel));
    chk("al_toggle", int'(tgl_b), int'(m_tgl));
    if (prs_a) begin press_cnt++; last_press = cyc; end
    if (rel_a) begin release_cnt++; last_release = cyc; end
  endtask

  task automatic hold(input logic v, input int n);
    btn = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int rise;
    int pc0;
    int rc0;
    logic v;
    int len;

    hist1 = 1'b0; hist2 = 1'b0; run = 0;
    m_lvl = 1'b0; m_prs = 1'b0; m_rel = 1'b0; m_tgl = 1'b0;
    rst = 1'b1;
    btn = 1'b0;

    // Reset with button released
    for (int i = 0; i < 3; i++) tick();
    chk("rst_level", int'(lvl_a), 0);
    chk("rst_toggle", int'(tgl_a), 0);
    rst = 1'b0;
    hold(1'b0, 4);

    // Clean press
    rise = cyc + 1;
    hold(1'b1, 20);
    chk("press_latency", last_press - rise, 10);
    chk("press_count", press_cnt, 1);
    chk("toggle_after_press", int'(tgl_a), 1);
    chk("level_held", int'(lvl_a), 1);

    // Clean release
    rise = cyc + 1;
    hold(1'b0, 20);
    chk("release_latency", last_release - rise, 10);
    chk("release_count", release_cnt, 1);
    chk("toggle_after_release", int'(tgl_a), 1);

    // Second press flips toggle back
    hold(1'b1, 20);
    chk("toggle_second_press", int'(tgl_a), 0);
    hold(1'b0, 20);

    // Bounce on the way in
    pc0 = press_cnt;
    hold(1'b1, 5);
    hold(1'b0, 2);
    rise = cyc + 1;
    hold(1'b1, 15);
    chk("bounce_single_press", press_cnt - pc0, 1);
    chk("bounce_latency", last_press - rise, 10);
    hold(1'b0, 20);

    // Short glitch never commits
    pc0 = press_cnt;
    rc0 = release_cnt;
    hold(1'b1, 7);
    hold(1'b0, 20);
    chk("glitch_no_press", press_cnt - pc0, 0);
    chk("glitch_no_release", release_cnt - rc0, 0);
    chk("glitch_level", int'(lvl_a), 0);

    // Reset during CHECK_HI with the button held
    pc0 = press_cnt;
    hold(1'b1, 5);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_mid_no_press", press_cnt - pc0, 0);
    rst = 1'b0;
    rise = cyc + 1;
    hold(1'b1, 15);
    chk("rst_mid_press_count", press_cnt - pc0, 1);
    chk("rst_mid_latency", last_press - rise, 10);
    hold(1'b0, 20);

    // Randomised segments with occasional resets
    v = 1'b0;
    for (int seg = 0; seg < 120; seg++) begin
      v = ~v;
      len = $urandom_range(14, 1);
      if ($urandom_range(9, 0) == 0) begin
        rst = 1'b1;
        btn = v;
        tick();
        rst = 1'b0;
      end
      hold(v, len);
    end
    hold(1'b0, 20);
    chk("final_level", int'(lvl_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
